// File: rtl/stopwatch_if.sv
// Button/tick inputs and control outputs of the stopwatch controller.
// The master side drives the button pulses; the slave side is the controller.
interface stopwatch_if;
  logic       start;
  logic       stop;
  logic       split;
  logic       tick_ms;
  logic       cnt_en;
  logic       cnt_clr;
  logic       disp_hold;
  logic       lap_we;
  logic [1:0] lap_addr;
  logic [2:0] lap_count;
  logic       blink;
  logic [1:0] state;

  modport master (
    output start, stop, split, tick_ms,
    input  cnt_en, cnt_clr, disp_hold, lap_we, lap_addr, lap_count, blink, state
  );

  modport slave (
    input  start, stop, split, tick_ms,
    output cnt_en, cnt_clr, disp_hold, lap_we, lap_addr, lap_count, blink, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: run/stop/split sequencing, lap register addressing,
// split-display hold timer and blink generator. All outputs registered.
module stopwatch_ctrl #(
  parameter int unsigned HOLD_MS  = 3000,
  parameter int unsigned BLINK_MS = 500
) (
  input  logic        clk,
  input  logic        rst,
  stopwatch_if.slave  sw
);

  localparam int unsigned TW = 12;
  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_MS - 1);
  localparam logic [TW-1:0] BLINK_LAST = TW'(BLINK_MS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    SPLIT = 2'b10,
    STOP  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] hold_q, hold_d;
  logic [TW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic          cnt_en_q, cnt_en_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic          disp_hold_q, disp_hold_d;
  logic          lap_we_q, lap_we_d;
  logic [1:0]    lap_addr_q, lap_addr_d;
  logic [2:0]    lap_count_q, lap_count_d;
  logic          capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      cnt_en_q    <= 1'b0;
      cnt_clr_q   <= 1'b0;
      disp_hold_q <= 1'b0;
      lap_we_q    <= 1'b0;
      lap_addr_q  <= '0;
      lap_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      cnt_en_q    <= cnt_en_d;
      cnt_clr_q   <= cnt_clr_d;
      disp_hold_q <= disp_hold_d;
      lap_we_q    <= lap_we_d;
      lap_addr_q  <= lap_addr_d;
      lap_count_q <= lap_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    cnt_clr_d   = 1'b0;
    lap_we_d    = 1'b0;
    capture     = 1'b0;
    // Address advances the cycle after each write strobe, so it always shows the slot being written.
    lap_addr_d  = lap_addr_q + 2'(lap_we_q);
    lap_count_d = lap_count_q;

    unique case (state_q)
      IDLE: begin
        if (sw.start) state_d = RUN;
      end
      RUN: begin
        if (sw.stop) begin
          state_d = STOP;
        end else if (sw.split) begin
          state_d = SPLIT;
          capture = 1'b1;
        end
      end
      SPLIT: begin
        if (sw.stop) begin
          state_d = STOP;
        end else if (sw.split) begin
          capture = 1'b1;
        end else if (sw.tick_ms) begin
          if (hold_q == '0) state_d = RUN;
          else              hold_d  = hold_q - TW'(1);
        end
      end
      STOP: begin
        if (sw.split) begin
          state_d     = IDLE;
          cnt_clr_d   = 1'b1;
          lap_addr_d  = '0;
          lap_count_d = '0;
        end else if (sw.start) begin
          state_d = RUN;
        end else if (sw.tick_ms) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
          end else begin
            blink_cnt_d = blink_cnt_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      lap_we_d    = 1'b1;
      hold_d      = HOLD_LOAD;
      lap_count_d = (lap_count_q == 3'd4) ? 3'd4 : lap_count_q + 3'd1;
    end

    // Timers only live in their own state; a tick on the entry edge is not counted.
    if (state_d != SPLIT) hold_d = '0;
    if (state_d != STOP) begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end else if (state_q != STOP) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end

    cnt_en_d    = (state_d == RUN) || (state_d == SPLIT);
    disp_hold_d = (state_d == SPLIT);
  end

  assign sw.state     = state_q;
  assign sw.cnt_en    = cnt_en_q;
  assign sw.cnt_clr   = cnt_clr_q;
  assign sw.disp_hold = disp_hold_q;
  assign sw.lap_we    = lap_we_q;
  assign sw.lap_addr  = lap_addr_q;
  assign sw.lap_count = lap_count_q;
  assign sw.blink     = blink_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with default HOLD_MS/BLINK_MS.
module tb_stopwatch_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  stopwatch_if sw ();
  stopwatch_ctrl #(.HOLD_MS(3000), .BLINK_MS(500)) dut (.clk(clk), .rst(rst), .sw(sw));

  always #5 clk = ~clk;

  // Drive a one-cycle combination of pulses; returns 1ns after the sampling edge.
  task automatic pulse(input logic st, input logic sp, input logic sl, input logic tk);
    sw.start = st; sw.stop = sp; sw.split = sl; sw.tick_ms = tk;
    @(posedge clk); #1;
    sw.start = 1'b0; sw.stop = 1'b0; sw.split = 1'b0; sw.tick_ms = 1'b0;
  endtask

  task automatic tick_n(input int n);
    sw.tick_ms = 1'b1;
    repeat (n) @(posedge clk);
    #1 sw.tick_ms = 1'b0;
  endtask

  function automatic logic [12:0] outs();
    return {sw.state, sw.cnt_en, sw.cnt_clr, sw.disp_hold, sw.lap_we,
            sw.lap_addr, sw.lap_count, sw.blink};
  endfunction

  task automatic test_reset();
    sw.start = 0; sw.stop = 0; sw.split = 0; sw.tick_ms = 0;
    rst = 1'b1;
    #23;
    checks++; if (outs() !== 13'd0) begin errors++; $display("FAIL reset_outs got %b exp %b", outs(), 13'd0); end
    rst = 1'b0;
    pulse(0, 1, 1, 0);
    checks++; if (outs() !== 13'd0) begin errors++; $display("FAIL idle_ignore got %b exp %b", outs(), 13'd0); end
  endtask

  task automatic test_start_stop();
    pulse(1, 0, 0, 0);
    checks++; if (sw.state !== 2'b01 || sw.cnt_en !== 1'b1 || sw.cnt_clr !== 1'b0) begin
      errors++; $display("FAIL start_run got st=%b en=%b clr=%b exp st=01 en=1 clr=0", sw.state, sw.cnt_en, sw.cnt_clr); end
    pulse(0, 1, 0, 0);
    checks++; if (sw.state !== 2'b11 || sw.cnt_en !== 1'b0 || sw.blink !== 1'b1) begin
      errors++; $display("FAIL stop got st=%b en=%b blink=%b exp st=11 en=0 blink=1", sw.state, sw.cnt_en, sw.blink); end
  endtask

  task automatic test_blink();
    tick_n(499);
    checks++; if (sw.blink !== 1'b1) begin errors++; $display("FAIL blink_499 got %b exp 1", sw.blink); end
    tick_n(1);
    checks++; if (sw.blink !== 1'b0) begin errors++; $display("FAIL blink_500 got %b exp 0", sw.blink); end
    tick_n(500);
    checks++; if (sw.blink !== 1'b1) begin errors++; $display("FAIL blink_1000 got %b exp 1", sw.blink); end
  endtask

  task automatic test_clear();
    pulse(0, 0, 1, 0);
    checks++; if (sw.cnt_clr !== 1'b1 || sw.state !== 2'b00 || sw.lap_count !== 3'd0 || sw.lap_addr !== 2'd0 || sw.blink !== 1'b0) begin
      errors++; $display("FAIL clear got clr=%b st=%b cnt=%0d addr=%0d blink=%b exp 1 00 0 0 0",
                         sw.cnt_clr, sw.state, sw.lap_count, sw.lap_addr, sw.blink); end
    pulse(0, 0, 0, 0);
    checks++; if (sw.cnt_clr !== 1'b0) begin errors++; $display("FAIL clear_one_cycle got %b exp 0", sw.cnt_clr); end
  endtask

  task automatic test_split_hold();
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    checks++; if (sw.lap_we !== 1'b1 || sw.lap_addr !== 2'd0 || sw.state !== 2'b10 || sw.disp_hold !== 1'b1 || sw.lap_count !== 3'd1) begin
      errors++; $display("FAIL split got we=%b addr=%0d st=%b hold=%b cnt=%0d exp 1 0 10 1 1",
                         sw.lap_we, sw.lap_addr, sw.state, sw.disp_hold, sw.lap_count); end
    tick_n(2999);
    checks++; if (sw.state !== 2'b10 || sw.lap_we !== 1'b0) begin
      errors++; $display("FAIL hold_2999 got st=%b we=%b exp 10 0", sw.state, sw.lap_we); end
    tick_n(1);
    checks++; if (sw.state !== 2'b01 || sw.disp_hold !== 1'b0 || sw.lap_count !== 3'd1 || sw.cnt_en !== 1'b1) begin
      errors++; $display("FAIL hold_expire got st=%b hold=%b cnt=%0d en=%b exp 01 0 1 1",
                         sw.state, sw.disp_hold, sw.lap_count, sw.cnt_en); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_addr [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [2:0] exp_cnt  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    pulse(0, 1, 0, 0);
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      pulse(0, 0, 1, 0);
      checks++; if (sw.lap_we !== 1'b1 || sw.lap_addr !== exp_addr[i] || sw.lap_count !== exp_cnt[i] || sw.state !== 2'b10) begin
        errors++; $display("FAIL b2b_split%0d got we=%b addr=%0d cnt=%0d st=%b exp 1 %0d %0d 10",
                           i, sw.lap_we, sw.lap_addr, sw.lap_count, sw.state, exp_addr[i], exp_cnt[i]); end
    end
    pulse(0, 0, 0, 0);
    checks++; if (sw.lap_we !== 1'b0 || sw.lap_addr !== 2'd1) begin
      errors++; $display("FAIL b2b_after got we=%b addr=%0d exp 0 1", sw.lap_we, sw.lap_addr); end
  endtask

  task automatic test_priority();
    pulse(0, 1, 1, 0);
    checks++; if (sw.state !== 2'b11 || sw.lap_we !== 1'b0) begin
      errors++; $display("FAIL split_stop_split got st=%b we=%b exp 11 0", sw.state, sw.lap_we); end
    pulse(1, 1, 0, 0);
    checks++; if (sw.state !== 2'b01 || sw.cnt_clr !== 1'b0 || sw.lap_count !== 3'd4) begin
      errors++; $display("FAIL stop_resume got st=%b clr=%b cnt=%0d exp 01 0 4", sw.state, sw.cnt_clr, sw.lap_count); end
    pulse(0, 1, 1, 0);
    checks++; if (sw.state !== 2'b11 || sw.lap_we !== 1'b0) begin
      errors++; $display("FAIL run_stop_split got st=%b we=%b exp 11 0", sw.state, sw.lap_we); end
    pulse(1, 0, 0, 1);
    pulse(1, 0, 1, 0);
    checks++; if (sw.state !== 2'b10 || sw.lap_we !== 1'b1 || sw.lap_addr !== 2'd1) begin
      errors++; $display("FAIL run_split_start got st=%b we=%b addr=%0d exp 10 1 1", sw.state, sw.lap_we, sw.lap_addr); end
    tick_n(2999);
    pulse(0, 0, 1, 1);
    checks++; if (sw.state !== 2'b10 || sw.lap_we !== 1'b1 || sw.lap_addr !== 2'd2) begin
      errors++; $display("FAIL split_over_expiry got st=%b we=%b addr=%0d exp 10 1 2", sw.state, sw.lap_we, sw.lap_addr); end
    tick_n(2999);
    checks++; if (sw.state !== 2'b10) begin errors++; $display("FAIL reload_2999 got %b exp 10", sw.state); end
    tick_n(1);
    checks++; if (sw.state !== 2'b01) begin errors++; $display("FAIL reload_expire got %b exp 01", sw.state); end
  endtask

  task automatic test_reset_mid();
    pulse(0, 0, 1, 0);
    tick_n(1499);
    checks++; if (sw.state !== 2'b10 || sw.disp_hold !== 1'b1) begin
      errors++; $display("FAIL pre_reset got st=%b hold=%b exp 10 1", sw.state, sw.disp_hold); end
    #2 rst = 1'b1;
    #1;
    checks++; if (outs() !== 13'd0) begin errors++; $display("FAIL async_reset got %b exp %b", outs(), 13'd0); end
    @(posedge clk); #3 rst = 1'b0;
    checks++; if (outs() !== 13'd0) begin errors++; $display("FAIL reset_release got %b exp %b", outs(), 13'd0); end
    pulse(1, 0, 0, 0);
    checks++; if (sw.state !== 2'b01 || sw.lap_count !== 3'd0 || sw.cnt_clr !== 1'b0) begin
      errors++; $display("FAIL post_reset_start got st=%b cnt=%0d clr=%b exp 01 0 0", sw.state, sw.lap_count, sw.cnt_clr); end
  endtask

  initial begin
    test_reset();
    test_start_stop();
    test_blink();
    test_clear();
    test_split_hold();
    test_back_to_back();
    test_priority();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter HOLD_MS, default 3000: number of tick_ms pulses a split display is frozen before automatic return to RUN; legal range 1..4095.
REQ-002 Parameter BLINK_MS, default 500: number of tick_ms pulses per half-period of the blink output in STOP; legal range 1..4095.
REQ-003 Port clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port start  input  1  single-cycle rising-edge pulse from the start button edge detector.
REQ-006 Port stop  input  1  single-cycle rising-edge pulse from the stop button edge detector.
REQ-007 Port split  input  1  single-cycle rising-edge pulse from the split button edge detector.
REQ-008 Port tick_ms  input  1  single-cycle pulse, once per millisecond, synchronous to clk.
REQ-009 Port cnt_en  output  1  enable to the time counters.
REQ-010 Port cnt_clr  output  1  single-cycle synchronous clear to the time counters.
REQ-011 Port disp_hold  output  1  display freeze (show captured lap, not live time).
REQ-012 Port lap_we  output  1  single-cycle write strobe to the lap register file.
REQ-013 Port lap_addr  output  2  lap register file write address.
REQ-014 Port lap_count  output  3  number of valid laps stored, 0..4.
REQ-015 Port blink  output  1  display blink enable.
REQ-016 Port state  output  2  current state code: IDLE=00, RUN=01, SPLIT=10, STOP=11.

Function
REQ-017 All outputs SHALL be registered; a qualifying input pulse at edge N SHALL produce its state and output changes at edge N+1 (one-cycle latency).
REQ-018 State machine SHALL have exactly four states: IDLE, RUN, SPLIT, STOP.
REQ-019 IDLE: start -> RUN; stop and split ignored.
REQ-020 RUN: stop -> STOP; split -> SPLIT with lap_we=1 at lap_addr and the hold timer loaded; start ignored.
REQ-021 SPLIT: stop -> STOP; split -> remain in SPLIT, capture a new lap (lap_we=1), and reload the hold timer; HOLD_MS tick_ms pulses counted since the last load -> RUN; start ignored.
REQ-022 STOP: start -> RUN (resume, counters not cleared); split -> IDLE with cnt_clr=1 for one cycle, lap_count and lap_addr cleared to 0.
REQ-023 Simultaneous pulses SHALL be resolved with priority stop > split > start; only the highest-priority pulse valid in the current state takes effect.
REQ-024 In SPLIT, a split pulse or stop pulse in the same cycle as hold-timer expiry SHALL take priority over expiry.
REQ-025 cnt_en SHALL be 1 in RUN and SPLIT and 0 in IDLE and STOP.
REQ-026 disp_hold SHALL be 1 only in SPLIT.
REQ-027 lap_addr SHALL increment modulo 4 on each lap_we and wrap 3 -> 0, overwriting the oldest lap.
REQ-028 lap_count SHALL increment on each lap_we, saturating at 4.
REQ-029 Hold timer: 12-bit down-counter, loaded with HOLD_MS-1 and decremented on tick_ms; expiry is a tick_ms pulse while the timer is 0.
REQ-030 Blink: 12-bit counter active only in STOP, advanced by tick_ms; blink SHALL toggle every BLINK_MS ticks, start at 1 on entry to STOP, and be 0 in all other states.
REQ-031 tick_ms coincident with a state-changing pulse: the pulse SHALL take effect; the tick SHALL NOT be counted by a timer in the new state.

Reset
REQ-032 While rst=1, at any point in any state: state=IDLE, cnt_en=0, cnt_clr=0, disp_hold=0, lap_we=0, lap_addr=0, lap_count=0, blink=0, and both timers=0.
REQ-033 The first edge after rst deasserts SHALL evaluate inputs normally; reset SHALL NOT itself generate a cnt_clr pulse.

Verification
REQ-034 Reset, then start -> state=01 and cnt_en=1 one cycle later; stop -> state=11, cnt_en=0, blink=1.
REQ-035 RUN, then split -> lap_we=1 with lap_addr=0, state=10, disp_hold=1; after HOLD_MS=3000 ticks -> state=01, disp_hold=0, lap_count=1.
REQ-036 Five splits in RUN/SPLIT -> lap_addr sequence 0,1,2,3,0, lap_count stays at 4, state remains 10.
REQ-037 stop and split asserted in the same cycle in RUN -> state=11, no lap_we.
REQ-038 STOP, then split -> cnt_clr=1 for exactly one cycle, state=00, lap_count=0, lap_addr=0, blink=0.
REQ-039 rst asserted mid-SPLIT with the timer at 1500 -> all outputs at reset values immediately (asynchronously); after release, start -> RUN with lap_count=0.
